pe_weight_packer: RTL
=====================

Name: pe_weight_packer

Overview:
- Upstream feeder of the PE weight buffer.
- Accepts the raw weight byte stream from the DDR read path (CONF_DDR_DATA_WIDTH = 8), one kernel at a time.
- Assembles each kernel into one PE_weight_t word: {A_9, B_6, C_6, D_4}, 200 bits.
- Writes each word to consecutive weight-buffer addresses. Supports 3x3 and 5x5 kernels and 8-bit or 4-bit weights.

Parameters:
- WT_DEPTH, CONF_WT_BUF_DEPTH (512), weight buffer depth; address wraps at this value.
- ADDR_W, $clog2(WT_DEPTH) (9), weight buffer address width.
- DIN_W, CONF_DDR_DATA_WIDTH (8), input byte width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle job start; sampled only in IDLE.
- cfg_kernel_mode  in  1  0: 3x3 (9 weights), 1: 5x5 (25 weights).
- cfg_bit_mode  in  1  0: 8-bit weights, 1: 4-bit weights.
- cfg_num_kernels  in  8  kernels in job, 1..250; 0 treated as 1.
- cfg_base_addr  in  ADDR_W  first write address.
- in_data  in  DIN_W  weight byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  packer accepts in_data.
- wt_wr_en  out  1  weight buffer write strobe.
- wt_wr_addr  out  ADDR_W  write address.
- wt_wr_data  out  200  packed PE_weight_t.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last write.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters and the assembly register cleared. Reset is asynchronous and aborts any job mid-kernel; no partial write is issued.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE -> LOAD on start:
  - latch all cfg_* inputs.
  - clear the assembly register and the weight index w_idx.
  - set kernel counter k_cnt = 0 and addr = cfg_base_addr.
  - busy = 1 from the next cycle.
- LOAD: in_ready = 1. Each in_valid & in_ready is a transfer.
  - 8-bit mode: one weight per transfer, stored at slot w_idx; w_idx += 1.
  - 4-bit mode: two weights per transfer, low nibble first. Each nibble is sign-extended to 8 bits and stored at slots w_idx and w_idx+1; w_idx += 2.
  - If only one slot remains (25th weight of 5x5, or 9th of 3x3), the high nibble is discarded.
  - Slot order: slot 0..8 -> A_9[0..8], 9..14 -> B_6[0..5], 15..20 -> C_6[0..5], 21..24 -> D_4[0..3].
  - Weights needed: N = 9 (3x3) or 25 (5x5). In 3x3 mode B_6, C_6 and D_4 stay 0.
  - The transfer that brings w_idx to >= N moves LOAD -> WRITE.
  - Bytes per kernel: 8-bit 9/25; 4-bit 5/13.
- WRITE (exactly 1 cycle, in_ready = 0):
  - wt_wr_en = 1, wt_wr_addr = addr, wt_wr_data = assembly register.
  - Latency: wt_wr_en is asserted in the cycle after the last byte of a kernel is accepted.
  - Then addr = (addr == WT_DEPTH-1) ? 0 : addr+1, k_cnt += 1, assembly register cleared, w_idx = 0.
  - If k_cnt+1 == num_kernels -> DONE, else -> LOAD.
- DONE: done = 1 for one cycle, busy = 0 the following cycle, -> IDLE.
- start while busy is ignored. cfg_* changes after start have no effect on the running job.
- in_valid with in_ready = 0 is not consumed; the source must hold its data.
- wt_wr_en, wt_wr_addr and wt_wr_data are registered outputs. wt_wr_data is held stable only while wt_wr_en = 1.
- Throughput: one kernel per (bytes_per_kernel + 1) cycles under continuous in_valid.

Test Plan:
- 5x5/8-bit, 1 kernel, base 0x010, bytes 1..25 back-to-back -> one write at addr 0x010. A_9 = 1..9, B_6 = 10..15, C_6 = 16..21, D_4 = 22..25. done 1 cycle later; in_ready low during WRITE.
- 3x3/8-bit, 3 kernels, base 0x1FE, bytes 0x01..0x1B -> writes at 0x1FE, 0x1FF, 0x000 (wrap). B/C/D = 0. Exactly 3 wt_wr_en pulses.
- 5x5/4-bit, 1 kernel, bytes 0x21, 0x43, …, last byte 0xF9 -> A_9[0] = 0x01, A_9[1] = 0x02, …, D_4[3] = 0xF9 sign-extended (0xF9 = -7). High nibble 0xF of the 13th byte dropped.
- 3x3/8-bit with in_valid toggling every other cycle -> identical packed word to the continuous case; no byte lost or duplicated.
- Reset asserted after 10 of 25 bytes -> all outputs 0 immediately. A new start then packs a fresh kernel with no leftover data.
- start pulsed mid-job with different cfg -> ignored; the original job completes with its original kernel count and base address.

Source files
------------

// File: rtl/pe_weight_packer_if.sv
// Stream-in / write-out bus of the PE weight packer.
//   in_data / in_valid / in_ready : weight byte stream from the DDR read path
//   wt_wr_en / wt_wr_addr / wt_wr_data : write port into the PE weight buffer
// The slave modport is the packer; the master modport is the byte source and
// the weight-buffer side seen together (e.g. a testbench).
interface pe_weight_packer_if #(
    parameter int ADDR_W = 9,
    parameter int DIN_W  = 8
);
    logic [DIN_W-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wt_wr_en;
    logic [ADDR_W-1:0] wt_wr_addr;
    logic [199:0]      wt_wr_data;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wt_wr_en,
        output wt_wr_addr,
        output wt_wr_data
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wt_wr_en,
        input  wt_wr_addr,
        input  wt_wr_data
    );
endinterface

// File: rtl/pe_weight_packer.sv
// PE weight packer: gathers one kernel's worth of weight bytes and writes it
// as a single 200-bit PE_weight_t word {A_9, B_6, C_6, D_4} to consecutive
// weight-buffer addresses (wrapping at WT_DEPTH).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               job start, sampled only when idle
//   cfg_kernel_mode     0: 3x3 (9 weights), 1: 5x5 (25 weights)
//   cfg_bit_mode        0: 8-bit weights, 1: 4-bit weights (two per byte)
//   cfg_num_kernels     kernels in the job (0 behaves as 1)
//   cfg_base_addr       first write address
//   bus (slave)         byte stream in, weight-buffer write port out
//   busy                high from accepted start until done
//   done                one-cycle pulse after the last write
module pe_weight_packer #(
    parameter int WT_DEPTH = 512,
    parameter int ADDR_W   = $clog2(WT_DEPTH),
    parameter int DIN_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_kernel_mode,
    input  logic              cfg_bit_mode,
    input  logic [7:0]        cfg_num_kernels,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    pe_weight_packer_if.slave bus,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Slot s holds weight s of the kernel, already widened to 8 bits.
    typedef logic [24:0][7:0] slots_t;

    // Place the 25 weight slots into the PE_weight_t bit layout. Element 0 of
    // each field sits at that field's least significant byte.
    function automatic logic [199:0] pack_word(input slots_t s);
        logic [199:0] w;
        w = 200'd0;
        for (int i = 0; i < 9; i++) w[128 + 8*i +: 8] = s[i];
        for (int i = 0; i < 6; i++) w[80  + 8*i +: 8] = s[9 + i];
        for (int i = 0; i < 6; i++) w[32  + 8*i +: 8] = s[15 + i];
        for (int i = 0; i < 4; i++) w[8*i +: 8]       = s[21 + i];
        return w;
    endfunction

    state_t            state_r;
    logic              kernel_mode_r;
    logic              bit_mode_r;
    logic [7:0]        num_kernels_r;
    logic [7:0]        k_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [4:0]        w_idx_r;
    slots_t            slots_r;
    logic              in_ready_r;
    logic              wt_wr_en_r;
    logic [ADDR_W-1:0] wt_wr_addr_r;
    logic [199:0]      wt_wr_data_r;
    logic              busy_r;
    logic              done_r;

    slots_t            slots_next_s;
    logic [4:0]        w_idx_p1_s;
    logic [4:0]        w_idx_next_s;
    logic [4:0]        need_s;
    logic [7:0]        lo_s;
    logic [7:0]        hi_s;

    assign bus.in_ready   = in_ready_r;
    assign bus.wt_wr_en   = wt_wr_en_r;
    assign bus.wt_wr_addr = wt_wr_addr_r;
    assign bus.wt_wr_data = wt_wr_data_r;
    assign busy           = busy_r;
    assign done           = done_r;

    // Assembly-register update for the byte currently on in_data.
    always_comb begin
        slots_next_s = slots_r;
        need_s       = kernel_mode_r ? 5'd25 : 5'd9;
        w_idx_p1_s   = w_idx_r + 5'd1;
        w_idx_next_s = w_idx_r + (bit_mode_r ? 5'd2 : 5'd1);
        lo_s         = {{4{bus.in_data[3]}}, bus.in_data[3:0]};
        hi_s         = {{4{bus.in_data[7]}}, bus.in_data[7:4]};
        if (bit_mode_r && (w_idx_p1_s < need_s)) begin
            slots_next_s[w_idx_r]    = lo_s;
            slots_next_s[w_idx_p1_s] = hi_s;
        end else if (bit_mode_r) begin
            // Only one slot left: the high nibble is dropped.
            slots_next_s[w_idx_r] = lo_s;
        end else begin
            slots_next_s[w_idx_r] = bus.in_data[7:0];
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            kernel_mode_r <= 1'b0;
            bit_mode_r    <= 1'b0;
            num_kernels_r <= 8'd0;
            k_cnt_r       <= 8'd0;
            addr_r        <= {ADDR_W{1'b0}};
            w_idx_r       <= 5'd0;
            slots_r       <= '0;
            in_ready_r    <= 1'b0;
            wt_wr_en_r    <= 1'b0;
            wt_wr_addr_r  <= {ADDR_W{1'b0}};
            wt_wr_data_r  <= 200'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r     <= 1'b0;
                    wt_wr_en_r <= 1'b0;
                    if (start) begin
                        kernel_mode_r <= cfg_kernel_mode;
                        bit_mode_r    <= cfg_bit_mode;
                        num_kernels_r <= (cfg_num_kernels == 8'd0) ? 8'd1 : cfg_num_kernels;
                        k_cnt_r       <= 8'd0;
                        addr_r        <= cfg_base_addr;
                        w_idx_r       <= 5'd0;
                        slots_r       <= '0;
                        in_ready_r    <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= S_LOAD;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    // in_ready_r is high throughout LOAD, so in_valid alone marks a transfer.
                    if (bus.in_valid) begin
                        slots_r <= slots_next_s;
                        if (w_idx_next_s >= need_s) begin
                            in_ready_r   <= 1'b0;
                            wt_wr_en_r   <= 1'b1;
                            wt_wr_addr_r <= addr_r;
                            wt_wr_data_r <= pack_word(slots_next_s);
                            state_r      <= S_WRITE;
                        end else begin
                            w_idx_r <= w_idx_next_s;
                        end
                    end else begin
                        state_r <= S_LOAD;
                    end
                end
                S_WRITE: begin
                    wt_wr_en_r   <= 1'b0;
                    wt_wr_data_r <= 200'd0;
                    addr_r       <= (addr_r == ADDR_W'(WT_DEPTH - 1)) ? {ADDR_W{1'b0}}
                                                                      : addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    k_cnt_r      <= k_cnt_r + 8'd1;
                    slots_r      <= '0;
                    w_idx_r      <= 5'd0;
                    if ((k_cnt_r + 8'd1) == num_kernels_r) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r    <= S_IDLE;
                    in_ready_r <= 1'b0;
                    wt_wr_en_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule
